// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - phase, light and direction types shared by the intersection scheduler
package traffic_pkg;

    typedef enum logic [2:0] {
        NS_GREEN     = 3'd0,
        NS_YELLOW    = 3'd1,
        ALLRED_A     = 3'd2,
        EW_GREEN     = 3'd3,
        EW_YELLOW    = 3'd4,
        ALLRED_B     = 3'd5,
        PREEMPT_HOLD = 3'd6
    } phase_t;

    typedef enum logic {
        DIR_NS = 1'b0,
        DIR_EW = 1'b1
    } dir_t;

    localparam logic [2:0] LIGHT_RED    = 3'b100;
    localparam logic [2:0] LIGHT_YELLOW = 3'b010;
    localparam logic [2:0] LIGHT_GREEN  = 3'b001;

    // A head shows green/yellow only in its own direction's phases; red everywhere else.
    function automatic logic [2:0] head_lights(input phase_t p, input dir_t d);
        logic [2:0] l;
        l = LIGHT_RED;
        if (d == DIR_NS) begin
            if (p == NS_GREEN)  l = LIGHT_GREEN;
            if (p == NS_YELLOW) l = LIGHT_YELLOW;
        end else begin
            if (p == EW_GREEN)  l = LIGHT_GREEN;
            if (p == EW_YELLOW) l = LIGHT_YELLOW;
        end
        return l;
    endfunction

endpackage

// File: rtl/traffic_phase_scheduler_if.sv
// rtl/traffic_phase_scheduler_if.sv - request/strobe inputs and head/walk outputs of the scheduler
interface traffic_phase_scheduler_if;
    import traffic_pkg::*;

    logic       tick_en;
    logic       ped_req_ns;
    logic       ped_req_ew;
    logic       preempt;
    logic [2:0] ns_lights;
    logic [2:0] ew_lights;
    logic       walk_ns;
    logic       walk_ew;
    phase_t     phase;

    modport master (
        output tick_en, ped_req_ns, ped_req_ew, preempt,
        input  ns_lights, ew_lights, walk_ns, walk_ew, phase
    );

    modport slave (
        input  tick_en, ped_req_ns, ped_req_ew, preempt,
        output ns_lights, ew_lights, walk_ns, walk_ew, phase
    );

endinterface

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - tick counter for the current phase; done on the strobe that completes dur ticks
module phase_timer #(
    parameter int TIMER_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clr,
    input  logic               tick_en,
    input  logic [TIMER_W-1:0] dur,
    output logic [TIMER_W-1:0] count,
    output logic               done
);

    // dur wraps to 0 when it equals 2**TIMER_W, and dur-1 then still yields the all-ones last count.
    assign done = tick_en && (count == dur - TIMER_W'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr || done) begin
            count <= '0;
        end else if (tick_en) begin
            count <= count + TIMER_W'(1);
        end
    end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// rtl/traffic_phase_scheduler.sv - two-approach phase FSM with pedestrian latches and emergency preemption
module traffic_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int TIMER_W      = 8,
    parameter int GREEN_TICKS  = 20,
    parameter int YELLOW_TICKS = 4,
    parameter int ALLRED_TICKS = 2,
    parameter int WALK_TICKS   = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    traffic_phase_scheduler_if.slave  bus
);

    localparam int MAX_DUR = (GREEN_TICKS > YELLOW_TICKS)
                           ? ((GREEN_TICKS > ALLRED_TICKS) ? GREEN_TICKS : ALLRED_TICKS)
                           : ((YELLOW_TICKS > ALLRED_TICKS) ? YELLOW_TICKS : ALLRED_TICKS);
    localparam logic [31:0] WALK_LIMIT = 32'(WALK_TICKS);

    generate
        if (WALK_TICKS < 1 || WALK_TICKS > GREEN_TICKS) begin : g_bad_walk
            $error("WALK_TICKS must lie in 1..GREEN_TICKS");
        end
        if (GREEN_TICKS < 1 || YELLOW_TICKS < 1 || ALLRED_TICKS < 1) begin : g_bad_dur
            $error("phase durations must be at least one tick");
        end
        if (TIMER_W < 1 || TIMER_W > 31 || (MAX_DUR - 1) >= (1 << TIMER_W)) begin : g_bad_width
            $error("TIMER_W cannot hold the longest phase duration minus one");
        end
    endgenerate

    phase_t             cur_phase;
    phase_t             next_phase;
    dir_t               last_served;
    logic               latch_ns;
    logic               latch_ew;
    logic               served_ns;
    logic               served_ew;
    logic               timer_clr;
    logic [TIMER_W-1:0] dur;
    logic [TIMER_W-1:0] timer;
    logic               timer_done;
    logic               enter_ns;
    logic               enter_ew;
    logic               walk_window;

    phase_timer #(.TIMER_W(TIMER_W)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clr     (timer_clr),
        .tick_en (bus.tick_en),
        .dur     (dur),
        .count   (timer),
        .done    (timer_done)
    );

    always_comb begin
        dur = TIMER_W'(ALLRED_TICKS);
        case (cur_phase)
            NS_GREEN, EW_GREEN:   dur = TIMER_W'(GREEN_TICKS);
            NS_YELLOW, EW_YELLOW: dur = TIMER_W'(YELLOW_TICKS);
            default:              ;
        endcase
    end

    // Preempt cuts a green short without waiting for a strobe; yellow and all-red always run their full time.
    always_comb begin
        next_phase = cur_phase;
        timer_clr  = 1'b0;
        case (cur_phase)
            NS_GREEN: begin
                if (bus.preempt) begin
                    next_phase = NS_YELLOW;
                    timer_clr  = 1'b1;
                end else if (timer_done) begin
                    next_phase = NS_YELLOW;
                end
            end
            EW_GREEN: begin
                if (bus.preempt) begin
                    next_phase = EW_YELLOW;
                    timer_clr  = 1'b1;
                end else if (timer_done) begin
                    next_phase = EW_YELLOW;
                end
            end
            NS_YELLOW: if (timer_done) next_phase = ALLRED_B;
            EW_YELLOW: if (timer_done) next_phase = ALLRED_A;
            ALLRED_A, ALLRED_B: begin
                if (timer_done) begin
                    if (bus.preempt)                next_phase = PREEMPT_HOLD;
                    else if (last_served == DIR_NS) next_phase = EW_GREEN;
                    else                            next_phase = NS_GREEN;
                end
            end
            PREEMPT_HOLD: begin
                timer_clr = 1'b1;
                if (!bus.preempt) next_phase = ALLRED_A;
            end
            default: begin
                next_phase = ALLRED_A;
                timer_clr  = 1'b1;
            end
        endcase
    end

    assign enter_ns = (next_phase == NS_GREEN) && (cur_phase != NS_GREEN);
    assign enter_ew = (next_phase == EW_GREEN) && (cur_phase != EW_GREEN);

    // A request seen on the entry edge itself belongs to the following green, so it refills the latch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_phase   <= ALLRED_A;
            last_served <= DIR_EW;
            latch_ns    <= 1'b0;
            latch_ew    <= 1'b0;
            served_ns   <= 1'b0;
            served_ew   <= 1'b0;
        end else begin
            cur_phase <= next_phase;
            if (enter_ns) begin
                last_served <= DIR_NS;
                served_ns   <= latch_ns;
                latch_ns    <= bus.ped_req_ns;
            end else begin
                latch_ns    <= latch_ns | bus.ped_req_ns;
            end
            if (enter_ew) begin
                last_served <= DIR_EW;
                served_ew   <= latch_ew;
                latch_ew    <= bus.ped_req_ew;
            end else begin
                latch_ew    <= latch_ew | bus.ped_req_ew;
            end
        end
    end

    assign walk_window   = (32'(timer) < WALK_LIMIT);
    assign bus.walk_ns   = (cur_phase == NS_GREEN) && served_ns && walk_window;
    assign bus.walk_ew   = (cur_phase == EW_GREEN) && served_ew && walk_window;
    assign bus.ns_lights = head_lights(cur_phase, DIR_NS);
    assign bus.ew_lights = head_lights(cur_phase, DIR_EW);
    assign bus.phase     = cur_phase;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// tb/tb_traffic_phase_scheduler.sv - self-checking bench for traffic_phase_scheduler against a tick-level model
module tb_traffic_phase_scheduler;
    import traffic_pkg::*;

    localparam int G  = 20;
    localparam int Y  = 4;
    localparam int AR = 2;
    localparam int W  = 8;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    traffic_phase_scheduler_if bus();

    traffic_phase_scheduler dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Model state: phase, ticks elapsed in it, walk ticks still owed, pending requests.
    phase_t m_phase;
    int     m_el;
    bit     m_last_ns;
    bit     m_req_ns;
    bit     m_req_ew;
    int     m_wl_ns;
    int     m_wl_ew;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int dur_of(input phase_t p);
        if (p == NS_GREEN || p == EW_GREEN)   return G;
        if (p == NS_YELLOW || p == EW_YELLOW) return Y;
        return AR;
    endfunction

    function automatic logic [2:0] exp_head(input phase_t p, input bit ns);
        if (ns) return (p == NS_GREEN) ? 3'b001 : (p == NS_YELLOW) ? 3'b010 : 3'b100;
        return (p == EW_GREEN) ? 3'b001 : (p == EW_YELLOW) ? 3'b010 : 3'b100;
    endfunction

    task automatic model_reset();
        m_phase = ALLRED_A; m_el = 0; m_last_ns = 1'b0;
        m_req_ns = 1'b0; m_req_ew = 1'b0; m_wl_ns = 0; m_wl_ew = 0;
    endtask

    task automatic model_step(input bit tk, input bit pr, input bit pn, input bit pe);
        phase_t nx;
        int     el;
        bit     fin;
        nx  = m_phase;
        el  = m_el;
        fin = tk && (m_el == dur_of(m_phase) - 1);
        case (m_phase)
            NS_GREEN, EW_GREEN: begin
                if (tk && m_phase == NS_GREEN && m_wl_ns > 0) m_wl_ns--;
                if (tk && m_phase == EW_GREEN && m_wl_ew > 0) m_wl_ew--;
                if (pr || fin) begin
                    nx = (m_phase == NS_GREEN) ? NS_YELLOW : EW_YELLOW;
                    el = 0;
                end else if (tk) el++;
            end
            NS_YELLOW, EW_YELLOW: begin
                if (fin) begin
                    nx = (m_phase == NS_YELLOW) ? ALLRED_B : ALLRED_A;
                    el = 0;
                end else if (tk) el++;
            end
            ALLRED_A, ALLRED_B: begin
                if (fin) begin
                    el = 0;
                    if (pr)             nx = PREEMPT_HOLD;
                    else if (m_last_ns) nx = EW_GREEN;
                    else                nx = NS_GREEN;
                end else if (tk) el++;
            end
            default: begin
                el = 0;
                if (!pr) nx = ALLRED_A;
            end
        endcase
        if (nx == NS_GREEN && m_phase != NS_GREEN) begin
            m_last_ns = 1'b1; m_wl_ns = m_req_ns ? W : 0; m_req_ns = pn;
        end else m_req_ns = m_req_ns | pn;
        if (nx == EW_GREEN && m_phase != EW_GREEN) begin
            m_last_ns = 1'b0; m_wl_ew = m_req_ew ? W : 0; m_req_ew = pe;
        end else m_req_ew = m_req_ew | pe;
        m_phase = nx;
        m_el    = el;
    endtask

    task automatic check_all();
        check_eq("phase",     32'(bus.phase),     32'(m_phase));
        check_eq("ns_lights", 32'(bus.ns_lights), 32'(exp_head(m_phase, 1'b1)));
        check_eq("ew_lights", 32'(bus.ew_lights), 32'(exp_head(m_phase, 1'b0)));
        check_eq("walk_ns",   32'(bus.walk_ns),   32'(m_phase == NS_GREEN && m_wl_ns > 0));
        check_eq("walk_ew",   32'(bus.walk_ew),   32'(m_phase == EW_GREEN && m_wl_ew > 0));
        check_eq("heads_conflict", 32'((bus.ns_lights != 3'b100) && (bus.ew_lights != 3'b100)), 32'd0);
    endtask

    task automatic step();
        @(posedge clk);
        model_step(bus.tick_en, bus.preempt, bus.ped_req_ns, bus.ped_req_ew);
        @(negedge clk);
        check_all();
    endtask

    task automatic run_until(input phase_t p, input string tag);
        int n;
        n = 0;
        while (bus.phase == p && n < 400) begin step(); n++; end
        while (bus.phase != p && n < 400) begin step(); n++; end
        check_eq(tag, 32'(bus.phase), 32'(p));
    endtask

    task automatic expect_phase(input string tag, input phase_t p);
        check_eq(tag, 32'(bus.phase), 32'(p));
    endtask

    task automatic count_walk_ns(input bit rerequest, output int cnt);
        int n;
        cnt = 0;
        n   = 0;
        while (bus.phase == NS_GREEN && n < 100) begin
            cnt += int'(bus.walk_ns);
            if (rerequest && n == 11) bus.ped_req_ns = 1'b1;
            step();
            bus.ped_req_ns = 1'b0;
            n++;
        end
    endtask

    initial begin
        int     first;
        int     second;
        int     bad;
        int     cnt;
        int     n;
        phase_t prev;

        reset = 1'b1;
        bus.tick_en = 1'b0; bus.ped_req_ns = 1'b0; bus.ped_req_ew = 1'b0; bus.preempt = 1'b0;
        repeat (2) @(negedge clk);
        model_reset();
        check_eq("reset_phase", 32'(bus.phase),     32'(ALLRED_A));
        check_eq("reset_ns",    32'(bus.ns_lights), 32'd4);
        check_eq("reset_ew",    32'(bus.ew_lights), 32'd4);
        check_eq("reset_walk",  32'({bus.walk_ns, bus.walk_ew}), 32'd0);
        reset = 1'b0;

        // Free-running strobe: full cycle period.
        first = -1; second = -1; prev = bus.phase;
        bus.tick_en = 1'b1;
        for (int i = 0; i < 130; i++) begin
            step();
            if (bus.phase == NS_GREEN && prev != NS_GREEN) begin
                if (first < 0) first = i;
                else if (second < 0) second = i;
            end
            prev = bus.phase;
        end
        check_eq("period_ticks", 32'(second - first), 32'(2 * (G + Y + AR)));

        // Strobe every 4th clock: phase may only change on strobe edges.
        bad = 0; prev = bus.phase;
        for (int i = 0; i < 260; i++) begin
            bus.tick_en = (i % 4 == 0);
            step();
            if (bus.phase != prev && !bus.tick_en) bad++;
            prev = bus.phase;
        end
        check_eq("phase_change_off_strobe", 32'(bad), 32'd0);

        // Pedestrian request during EW green, re-request mid NS green, then no request.
        bus.tick_en = 1'b1;
        run_until(EW_GREEN, "wait_ew_green");
        bus.ped_req_ns = 1'b1; step(); bus.ped_req_ns = 1'b0;
        run_until(NS_GREEN, "wait_ns_green_1");
        count_walk_ns(1'b1, cnt);
        check_eq("walk_ns_ticks_1", 32'(cnt), 32'(W));
        run_until(NS_GREEN, "wait_ns_green_2");
        count_walk_ns(1'b0, cnt);
        check_eq("walk_ns_ticks_2", 32'(cnt), 32'(W));
        run_until(NS_GREEN, "wait_ns_green_3");
        count_walk_ns(1'b0, cnt);
        check_eq("walk_ns_ticks_3", 32'(cnt), 32'd0);

        // Preempt at NS green tick 5.
        run_until(NS_GREEN, "wait_ns_green_pre");
        n = 0;
        while (m_el < 5 && n < 50) begin step(); n++; end
        bus.preempt = 1'b1;
        step();                 expect_phase("pre1_yellow", NS_YELLOW);
        repeat (3) step();      expect_phase("pre1_yellow_end", NS_YELLOW);
        step();                 expect_phase("pre1_allred_b", ALLRED_B);
        repeat (2) step();      expect_phase("pre1_hold", PREEMPT_HOLD);
        repeat (5) step();      expect_phase("pre1_hold_stay", PREEMPT_HOLD);
        bus.preempt = 1'b0;
        step();                 expect_phase("pre1_clear", ALLRED_A);
        step();                 expect_phase("pre1_clear_2", ALLRED_A);
        step();                 expect_phase("pre1_ew_green", EW_GREEN);

        // Preempt at EW yellow tick 1.
        run_until(EW_YELLOW, "wait_ew_yellow");
        step();
        bus.preempt = 1'b1;
        repeat (2) step();      expect_phase("pre2_yellow", EW_YELLOW);
        step();                 expect_phase("pre2_allred_a", ALLRED_A);
        repeat (2) step();      expect_phase("pre2_hold", PREEMPT_HOLD);
        bus.preempt = 1'b0;
        step();                 expect_phase("pre2_clear", ALLRED_A);
        repeat (2) step();      expect_phase("pre2_ns_green", NS_GREEN);

        // Asynchronous reset mid EW green.
        bus.ped_req_ew = 1'b1; step(); bus.ped_req_ew = 1'b0;
        run_until(EW_GREEN, "wait_ew_green_rst");
        repeat (3) step();
        bus.ped_req_ns = 1'b1;
        #2 reset = 1'b1;
        #1;
        check_eq("arst_phase", 32'(bus.phase),     32'(ALLRED_A));
        check_eq("arst_ns",    32'(bus.ns_lights), 32'd4);
        check_eq("arst_ew",    32'(bus.ew_lights), 32'd4);
        check_eq("arst_walk",  32'({bus.walk_ns, bus.walk_ew}), 32'd0);
        @(negedge clk);
        bus.ped_req_ns = 1'b0;
        reset = 1'b0;
        model_reset();
        repeat (60) step();

        // Randomised strobes, requests and preemption episodes.
        for (int i = 0; i < 3000; i++) begin
            bus.tick_en    = ($urandom_range(0, 2) != 0);
            bus.ped_req_ns = ($urandom_range(0, 19) == 0);
            bus.ped_req_ew = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 149) == 0) bus.preempt = ~bus.preempt;
            step();
        end
        bus.preempt = 1'b0; bus.ped_req_ns = 1'b0; bus.ped_req_ew = 1'b0; bus.tick_en = 1'b1;
        repeat (60) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
